dbg_reg_resp: RTL and testbench

DBG_REG_RESP -- requirements
Module: dbg_reg_resp

---
 rtl/dbg_reg_resp_pkg.sv | 42 ++++
 rtl/dbg_reg_resp_tmo_cnt.sv | 29 ++
 rtl/dbg_reg_resp.sv | 167 ++++++++++++++++
 tb/tb_dbg_reg_resp.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_reg_resp_pkg.sv
// Shared definitions for the debug register access responder:
// FSM states, regno decode bounds, bus widths and the regno decoder.
package dbg_reg_resp_pkg;

  localparam int unsigned REGNO_W = 16;
  localparam int unsigned ADDR_W  = 12;

  // regno map: CSRs occupy 0x0000-0x0FFF, GPRs 0x1000-0x101F
  localparam logic [REGNO_W-1:0] CSR_HI = 16'h0FFF;
  localparam logic [REGNO_W-1:0] GPR_LO = 16'h1000;
  localparam logic [REGNO_W-1:0] GPR_HI = 16'h101F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              csr;
    logic [ADDR_W-1:0] addr;
  } decode_t;

  // Map an abstract register number onto the CSR or GPR file
  function automatic decode_t decode_regno(input logic [REGNO_W-1:0] regno);
    decode_t d;
    d = '0;
    if (regno <= CSR_HI) begin
      d.valid = 1'b1;
      d.csr   = 1'b1;
      d.addr  = regno[ADDR_W-1:0];
    end else if ((regno >= GPR_LO) && (regno <= GPR_HI)) begin
      d.valid = 1'b1;
      d.csr   = 1'b0;
      d.addr  = {7'b0, regno[4:0]};
    end
    return d;
  endfunction

endpackage

// File: rtl/dbg_reg_resp_tmo_cnt.sv
// Timeout counter: counts cycles spent waiting for grant or read data and
// flags expiry on the LIMIT-th waiting cycle.
module dbg_tmo_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned    W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  // Count waiting cycles; clear wins so the count restarts at each new wait
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/dbg_reg_resp.sv
// Debug abstract register access responder: accepts one access at a time,
// drives the core register-file port, and reports completion/error pulses.
module dbg_reg_resp
  import dbg_reg_resp_pkg::*;
#(
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                valid_reg_access,
  input  logic                wr1_rd0,
  input  logic [REGNO_W-1:0]  regno,
  input  logic [31:0]         write_data,
  input  logic                core_halted,
  output logic                read_data_valid,
  output logic [31:0]         read_data,
  output logic                cmd_err,
  output logic                req_overrun,
  input  logic                clr_overrun,
  output logic                dbg_rf_req,
  input  logic                dbg_rf_gnt,
  output logic                dbg_csr_sel,
  output logic                dbg_rf_we,
  output logic [ADDR_W-1:0]   dbg_rf_addr,
  output logic [31:0]         dbg_rf_wdata,
  input  logic                dbg_rf_rvalid,
  input  logic [31:0]         dbg_rf_rdata
);

  state_t              r_state;
  logic                r_wr;
  logic [31:0]         r_wdata;
  logic                r_csr_sel;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_req;
  logic                r_rdv;
  logic                r_cmd_err;
  logic [31:0]         r_rdata;
  logic                r_overrun;

  decode_t             w_dec;
  logic                w_bad;
  logic                w_tmo_clr;
  logic                w_tmo_en;
  logic                w_expired;

  // Decode the incoming request and derive timeout counter controls
  always_comb begin
    w_dec     = decode_regno(regno);
    w_bad     = !w_dec.valid || !core_halted;
    w_tmo_clr = 1'b0;
    w_tmo_en  = 1'b0;
    if ((r_state == ST_IDLE) && valid_reg_access && !w_bad) begin
      w_tmo_clr = 1'b1;
    end
    if ((r_state == ST_REQ) && dbg_rf_gnt && !r_wr) begin
      w_tmo_clr = 1'b1;
    end
    if ((r_state == ST_REQ) || (r_state == ST_WAIT_RD)) begin
      w_tmo_en = 1'b1;
    end
  end

  dbg_tmo_cnt #(
    .LIMIT (GNT_TIMEOUT)
  ) u_tmo (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  // Access FSM; completion/error pulses are set on the edge entering DONE so
  // they are high exactly while the FSM sits in DONE
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_csr_sel <= 1'b0;
      r_addr    <= '0;
      r_req     <= 1'b0;
      r_rdv     <= 1'b0;
      r_cmd_err <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rdv     <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_reg_access) begin
            r_wr      <= wr1_rd0;
            r_wdata   <= write_data;
            r_csr_sel <= w_dec.csr;
            r_addr    <= w_dec.addr;
            if (w_bad) begin
              r_state   <= ST_DONE;
              r_cmd_err <= 1'b1;
              if (!wr1_rd0) begin
                r_rdv   <= 1'b1;
                r_rdata <= '0;
              end
            end else begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (dbg_rf_gnt) begin
            r_req   <= 1'b0;
            r_state <= r_wr ? ST_DONE : ST_WAIT_RD;
          end else if (w_expired) begin
            r_req     <= 1'b0;
            r_state   <= ST_DONE;
            r_cmd_err <= 1'b1;
            if (!r_wr) begin
              r_rdv   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        ST_WAIT_RD: begin
          if (dbg_rf_rvalid) begin
            r_rdata <= dbg_rf_rdata;
            r_rdv   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_expired) begin
            r_rdata   <= '0;
            r_rdv     <= 1'b1;
            r_cmd_err <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a dropped request in the same cycle as clear wins
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_overrun <= 1'b0;
    end else if (valid_reg_access && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign read_data_valid = r_rdv;
  assign read_data       = r_rdata;
  assign cmd_err         = r_cmd_err;
  assign req_overrun     = r_overrun;
  assign dbg_rf_req      = r_req;
  assign dbg_csr_sel     = r_csr_sel;
  assign dbg_rf_we       = r_wr;
  assign dbg_rf_addr     = r_addr;
  assign dbg_rf_wdata    = r_wdata;

endmodule

// File: tb/tb_dbg_reg_resp.sv
// Scoreboard bench for dbg_reg_resp: directed accesses push expected
// responses; a negedge monitor pops and compares on each DUT pulse.
module tb_dbg_reg_resp;

  typedef struct {
    logic        rdv;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic        sys_clk;
  logic        sys_rst;
  logic        valid_reg_access;
  logic        valid_reg_access_4;
  logic        wr1_rd0;
  logic [15:0] regno;
  logic [31:0] write_data;
  logic        core_halted;
  logic        clr_overrun;
  logic        dbg_rf_gnt;
  logic        dbg_rf_rvalid;
  logic [31:0] dbg_rf_rdata;

  logic        read_data_valid,  read_data_valid_4;
  logic [31:0] read_data,        read_data_4;
  logic        cmd_err,          cmd_err_4;
  logic        req_overrun,      req_overrun_4;
  logic        dbg_rf_req,       dbg_rf_req_4;
  logic        dbg_csr_sel,      dbg_csr_sel_4;
  logic        dbg_rf_we,        dbg_rf_we_4;
  logic [11:0] dbg_rf_addr,      dbg_rf_addr_4;
  logic [31:0] dbg_rf_wdata,     dbg_rf_wdata_4;

  int    n_checks = 0;
  int    n_errors = 0;
  resp_t q[$];
  resp_t q4[$];

  dbg_reg_resp #(.GNT_TIMEOUT(255)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .valid_reg_access(valid_reg_access), .wr1_rd0(wr1_rd0),
    .regno(regno), .write_data(write_data), .core_halted(core_halted),
    .read_data_valid(read_data_valid), .read_data(read_data),
    .cmd_err(cmd_err), .req_overrun(req_overrun), .clr_overrun(clr_overrun),
    .dbg_rf_req(dbg_rf_req), .dbg_rf_gnt(dbg_rf_gnt),
    .dbg_csr_sel(dbg_csr_sel), .dbg_rf_we(dbg_rf_we),
    .dbg_rf_addr(dbg_rf_addr), .dbg_rf_wdata(dbg_rf_wdata),
    .dbg_rf_rvalid(dbg_rf_rvalid), .dbg_rf_rdata(dbg_rf_rdata)
  );

  dbg_reg_resp #(.GNT_TIMEOUT(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .valid_reg_access(valid_reg_access_4), .wr1_rd0(wr1_rd0),
    .regno(regno), .write_data(write_data), .core_halted(core_halted),
    .read_data_valid(read_data_valid_4), .read_data(read_data_4),
    .cmd_err(cmd_err_4), .req_overrun(req_overrun_4), .clr_overrun(clr_overrun),
    .dbg_rf_req(dbg_rf_req_4), .dbg_rf_gnt(dbg_rf_gnt),
    .dbg_csr_sel(dbg_csr_sel_4), .dbg_rf_we(dbg_rf_we_4),
    .dbg_rf_addr(dbg_rf_addr_4), .dbg_rf_wdata(dbg_rf_wdata_4),
    .dbg_rf_rvalid(dbg_rf_rvalid), .dbg_rf_rdata(dbg_rf_rdata)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Monitor: every completion/error pulse must match the oldest expectation
  always @(negedge sys_clk) begin : mon
    resp_t e;
    if (read_data_valid || cmd_err) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, read_data_valid, cmd_err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("resp_rdv", {31'd0, read_data_valid}, {31'd0, e.rdv});
        chk("resp_err", {31'd0, cmd_err}, {31'd0, e.err});
        if (e.rdv) chk("resp_data", read_data, e.data);
      end
    end
    if (read_data_valid_4 || cmd_err_4) begin
      if (q4.size() == 0) begin
        chk("unexpected_pulse_t4", {30'd0, read_data_valid_4, cmd_err_4}, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("resp4_rdv", {31'd0, read_data_valid_4}, {31'd0, e.rdv});
        chk("resp4_err", {31'd0, cmd_err_4}, {31'd0, e.err});
        if (e.rdv) chk("resp4_data", read_data_4, e.data);
      end
    end
  end

  initial begin
    sys_rst = 1'b1; valid_reg_access = 1'b0; valid_reg_access_4 = 1'b0;
    wr1_rd0 = 1'b0; regno = '0; write_data = '0; core_halted = 1'b1;
    clr_overrun = 1'b0; dbg_rf_gnt = 1'b0; dbg_rf_rvalid = 1'b0; dbg_rf_rdata = '0;
    tick(); tick();
    chk("rst_rdv", {31'd0, read_data_valid}, 32'd0);
    chk("rst_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_ovr", {31'd0, req_overrun}, 32'd0);
    chk("rst_req", {31'd0, dbg_rf_req}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    sys_rst = 1'b0;
    tick();

    // Minimum-latency GPR read
    valid_reg_access = 1'b1; wr1_rd0 = 1'b0; regno = 16'h1005;
    tick();
    valid_reg_access = 1'b0;
    chk("rd_req", {31'd0, dbg_rf_req}, 32'd1);
    chk("rd_sel", {31'd0, dbg_csr_sel}, 32'd0);
    chk("rd_addr", {20'd0, dbg_rf_addr}, 32'h005);
    chk("rd_we", {31'd0, dbg_rf_we}, 32'd0);
    dbg_rf_gnt = 1'b1;
    q.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
    tick();
    dbg_rf_gnt = 1'b0;
    chk("rd_req_drop", {31'd0, dbg_rf_req}, 32'd0);
    dbg_rf_rvalid = 1'b1; dbg_rf_rdata = 32'hDEADBEEF;
    tick();
    dbg_rf_rvalid = 1'b0; dbg_rf_rdata = '0;
    chk("rd_latency3", {31'd0, read_data_valid}, 32'd1);
    tick();
    chk("rd_pulse_1cyc", {31'd0, read_data_valid}, 32'd0);
    chk("rd_hold", read_data, 32'hDEADBEEF);

    // CSR write with grant in the 10th REQ cycle; halt drops mid-flight
    valid_reg_access = 1'b1; wr1_rd0 = 1'b1; regno = 16'h0300; write_data = 32'h00001888;
    tick();
    valid_reg_access = 1'b0; write_data = '0;
    for (int i = 0; i < 10; i++) begin
      chk("wr_req", {31'd0, dbg_rf_req}, 32'd1);
      chk("wr_we", {31'd0, dbg_rf_we}, 32'd1);
      chk("wr_addr", {20'd0, dbg_rf_addr}, 32'h300);
      chk("wr_sel", {31'd0, dbg_csr_sel}, 32'd1);
      chk("wr_wdata", dbg_rf_wdata, 32'h00001888);
      if (i == 5) core_halted = 1'b0;
      if (i == 9) dbg_rf_gnt = 1'b1;
      tick();
    end
    dbg_rf_gnt = 1'b0; core_halted = 1'b1;
    chk("wr_done_req", {31'd0, dbg_rf_req}, 32'd0);
    chk("wr_no_rdv", {31'd0, read_data_valid}, 32'd0);
    chk("wr_no_err", {31'd0, cmd_err}, 32'd0);
    tick();
    chk("wr_rdata_kept", read_data, 32'hDEADBEEF);

    // Invalid regno read: immediate error completion with zero data
    valid_reg_access = 1'b1; wr1_rd0 = 1'b0; regno = 16'h2000;
    q.push_back('{1'b1, 1'b1, 32'h0});
    tick();
    valid_reg_access = 1'b0;
    chk("inv_no_req", {31'd0, dbg_rf_req}, 32'd0);
    chk("inv_done_next", {31'd0, read_data_valid}, 32'd1);
    tick();
    chk("inv_no_req2", {31'd0, dbg_rf_req}, 32'd0);
    chk("inv_rdata0", read_data, 32'd0);

    // Write while not halted: error only, no read completion
    core_halted = 1'b0;
    valid_reg_access = 1'b1; wr1_rd0 = 1'b1; regno = 16'h0010;
    q.push_back('{1'b0, 1'b1, 32'h0});
    tick();
    valid_reg_access = 1'b0;
    chk("nh_no_req", {31'd0, dbg_rf_req}, 32'd0);
    chk("nh_err", {31'd0, cmd_err}, 32'd1);
    tick();
    core_halted = 1'b1;

    // GNT_TIMEOUT=4 instance: one good read, then a grant timeout
    valid_reg_access_4 = 1'b1; wr1_rd0 = 1'b0; regno = 16'h1001;
    tick();
    valid_reg_access_4 = 1'b0;
    chk("t4_req", {31'd0, dbg_rf_req_4}, 32'd1);
    chk("t4_sel_addr", {19'd0, dbg_csr_sel_4, dbg_rf_addr_4}, 32'h001);
    chk("t4_we_wdata", {31'd0, dbg_rf_we_4} | dbg_rf_wdata_4, 32'd0);
    dbg_rf_gnt = 1'b1;
    q4.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
    tick();
    dbg_rf_gnt = 1'b0; dbg_rf_rvalid = 1'b1; dbg_rf_rdata = 32'hCAFEF00D;
    tick();
    dbg_rf_rvalid = 1'b0; dbg_rf_rdata = '0;
    tick();
    valid_reg_access_4 = 1'b1; wr1_rd0 = 1'b0; regno = 16'h0001;
    q4.push_back('{1'b1, 1'b1, 32'h0});
    tick();
    valid_reg_access_4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req_held", {31'd0, dbg_rf_req_4}, 32'd1);
      tick();
    end
    chk("tmo_abort", {31'd0, read_data_valid_4 & cmd_err_4}, 32'd1);
    chk("tmo_req_drop", {31'd0, dbg_rf_req_4}, 32'd0);
    tick();

    // Overrun while in WAIT_RD, plus grant and rvalid together in REQ
    valid_reg_access = 1'b1; wr1_rd0 = 1'b0; regno = 16'h0001;
    tick();
    valid_reg_access = 1'b0;
    dbg_rf_gnt = 1'b1; dbg_rf_rvalid = 1'b1; dbg_rf_rdata = 32'hBAD0BAD0;
    q.push_back('{1'b1, 1'b0, 32'h600DF00D});
    tick();
    dbg_rf_gnt = 1'b0; dbg_rf_rvalid = 1'b0; dbg_rf_rdata = '0;
    chk("ovr_before", {31'd0, req_overrun}, 32'd0);
    valid_reg_access = 1'b1; wr1_rd0 = 1'b1; regno = 16'h1002;
    tick();
    chk("ovr_set", {31'd0, req_overrun}, 32'd1);
    clr_overrun = 1'b1;
    tick();
    valid_reg_access = 1'b0; clr_overrun = 1'b0;
    chk("ovr_set_wins", {31'd0, req_overrun}, 32'd1);
    dbg_rf_rvalid = 1'b1; dbg_rf_rdata = 32'h600DF00D;
    tick();
    dbg_rf_rvalid = 1'b0; dbg_rf_rdata = '0;
    chk("ovr_first_done", {31'd0, read_data_valid}, 32'd1);
    tick();
    chk("ovr_sticky", {31'd0, req_overrun}, 32'd1);
    chk("ovr_dropped_no_req", {31'd0, dbg_rf_req}, 32'd0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clr", {31'd0, req_overrun}, 32'd0);

    // Reset while in REQ abandons the access silently
    valid_reg_access = 1'b1; wr1_rd0 = 1'b0; regno = 16'h1003;
    tick();
    valid_reg_access = 1'b0;
    chk("rr_req", {31'd0, dbg_rf_req}, 32'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rr_req_off", {31'd0, dbg_rf_req}, 32'd0);
    chk("rr_no_pulse", {30'd0, read_data_valid, cmd_err}, 32'd0);
    chk("rr_rdata0", read_data, 32'd0);
    tick();
    chk("rr_idle", {30'd0, dbg_rf_req, read_data_valid}, 32'd0);
    valid_reg_access = 1'b1; wr1_rd0 = 1'b0; regno = 16'h101F;
    q.push_back('{1'b1, 1'b0, 32'h13572468});
    tick();
    valid_reg_access = 1'b0;
    chk("rr_addr", {20'd0, dbg_rf_addr}, 32'h01F);
    dbg_rf_gnt = 1'b1;
    tick();
    dbg_rf_gnt = 1'b0; dbg_rf_rvalid = 1'b1; dbg_rf_rdata = 32'h13572468;
    tick();
    dbg_rf_rvalid = 1'b0; dbg_rf_rdata = '0;
    chk("rr_after_done", {31'd0, read_data_valid}, 32'd1);
    tick();

    repeat (3) tick();
    chk("sb_drained", q.size() + q4.size(), 32'd0);
    chk("t4_no_overrun", {31'd0, req_overrun_4}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
